// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter serialising two requesters onto a RAM read/write port
module ram_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  state_t state;
  logic owner_b, owner_we, last_b, pick_b, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  // on a tie the requester not granted last wins
  always_comb begin
    pick_b = b_req & (~a_req | ~last_b);
    sel_we = pick_b ? b_we : a_we;
    sel_addr = pick_b ? b_addr : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      owner_b <= 1'b0;
      owner_we <= 1'b0;
      last_b <= 1'b1;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      ram_wr_en <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en <= 1'b0;
      ram_rd_addr <= '0;
      busy <= 1'b0;
    end else begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      case (state)
        IDLE: if (a_req | b_req) begin
          owner_b <= pick_b;
          owner_we <= sel_we;
          last_b <= pick_b;
          a_gnt <= ~pick_b;
          b_gnt <= pick_b;
          if (sel_we) begin
            ram_wr_en <= 1'b1;
            ram_wr_addr <= sel_addr;
            ram_wr_data <= sel_wdata;
          end else begin
            ram_rd_en <= 1'b1;
            ram_rd_addr <= sel_addr;
          end
          state <= ISSUE;
          busy <= 1'b1;
        end
        ISSUE: begin
          state <= owner_we ? IDLE : RDWAIT;
          busy <= ~owner_we;
        end
        RDWAIT: begin
          if (owner_b) b_rdata <= ram_rd_data;
          else a_rdata <= ram_rd_data;
          a_rvalid <= ~owner_b;
          b_rvalid <= owner_b;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wr_en, ram_rd_en, busy;
  logic [DW-1:0] a_rdata, b_rdata, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM with registered read; unwritten locations read as zero
  logic [DW-1:0] mem [256];
  bit [255:0] vld;
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr[7:0]] <= ram_wr_data;
      vld[ram_wr_addr[7:0]] <= 1'b1;
    end
    if (ram_rd_en) ram_rd_data <= vld[ram_rd_addr[7:0]] ? mem[ram_rd_addr[7:0]] : '0;
  end

  typedef struct {
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cmd_t;
  typedef struct {
    bit a_v; logic a_w; logic [AW-1:0] a_ad; logic [DW-1:0] a_wd;
    bit b_v; logic b_w; logic [AW-1:0] b_ad; logic [DW-1:0] b_wd;
    int a_off; int b_off;
    logic [DW-1:0] a_rd; logic [DW-1:0] b_rd;
  } vec_t;

  cmd_t aq[$], bq[$];
  bit glog[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, idle_from = 0, rv_at = -1, a_gcyc = -1, b_gcyc = -1, b_rv_cnt = 0;
  bit rst_drv = 1'b1, last_b = 1'b1, rv_b = 1'b0;
  logic [DW-1:0] rv_data;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_wr_en, e_rd_en, e_busy;
  logic [DW-1:0] e_a_rdata, e_b_rdata, e_wr_data;
  logic [AW-1:0] e_wr_addr, e_rd_addr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    rst = rst_drv;
    a_req = aq.size() != 0;
    b_req = bq.size() != 0;
    {a_we, a_addr, a_wdata} = a_req ? {aq[0].we, aq[0].addr, aq[0].wd} : {1'($urandom), $urandom, $urandom};
    {b_we, b_addr, b_wdata} = b_req ? {bq[0].we, bq[0].addr, bq[0].wd} : {1'($urandom), $urandom, $urandom};
  endtask

  // expected outputs for the next cycle, from the transaction rules and command timing
  task automatic predict();
    int n = cyc + 1;
    bit pb;
    logic w;
    logic [AW-1:0] ad;
    {e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_wr_en, e_rd_en} = '0;
    if (rst) begin
      {e_wr_addr, e_wr_data, e_rd_addr, e_a_rdata, e_b_rdata, e_busy} = '0;
      idle_from = n;
      last_b = 1'b1;
      rv_at = -1;
    end else begin
      if (rv_at == n) begin
        if (rv_b) begin e_b_rv = 1'b1; e_b_rdata = rv_data; end
        else begin e_a_rv = 1'b1; e_a_rdata = rv_data; end
      end
      if (cyc >= idle_from && (a_req || b_req)) begin
        pb = (a_req && b_req) ? !last_b : b_req;
        last_b = pb;
        w = pb ? b_we : a_we;
        ad = pb ? b_addr : a_addr;
        e_a_gnt = !pb;
        e_b_gnt = pb;
        if (w) begin
          e_wr_en = 1'b1;
          e_wr_addr = ad;
          e_wr_data = pb ? b_wdata : a_wdata;
          ref_mem[ad] = e_wr_data;
          idle_from = n + 1;
        end else begin
          e_rd_en = 1'b1;
          e_rd_addr = ad;
          rv_at = n + 2;
          rv_b = pb;
          rv_data = ref_mem.exists(ad) ? ref_mem[ad] : '0;
          idle_from = n + 2;
        end
      end
      e_busy = n < idle_from;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("a_gnt", 32'(a_gnt), 32'(e_a_gnt));
    chk("b_gnt", 32'(b_gnt), 32'(e_b_gnt));
    chk("a_rvalid", 32'(a_rvalid), 32'(e_a_rv));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_b_rv));
    chk("a_rdata", a_rdata, e_a_rdata);
    chk("b_rdata", b_rdata, e_b_rdata);
    chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr_en));
    chk("ram_wr_addr", ram_wr_addr, e_wr_addr);
    chk("ram_wr_data", ram_wr_data, e_wr_data);
    chk("ram_rd_en", 32'(ram_rd_en), 32'(e_rd_en));
    chk("ram_rd_addr", ram_rd_addr, e_rd_addr);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("en_exclusive", 32'(ram_wr_en & ram_rd_en), 32'd0);
    if (a_gnt) begin a_gcyc = cyc; glog.push_back(1'b0); if (aq.size() != 0) void'(aq.pop_front()); end
    if (b_gnt) begin b_gcyc = cyc; glog.push_back(1'b1); if (bq.size() != 0) void'(bq.pop_front()); end
    if (b_rvalid) b_rv_cnt++;
    drive();
    predict();
  endtask

  task automatic run_until_idle(int max);
    int k = 0;
    while ((aq.size() != 0 || bq.size() != 0 || cyc < idle_from) && k < max) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k >= max), 32'd0);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    tick();
    tick();
    rst_drv = 1'b0;
  endtask

  function automatic cmd_t mk(logic w, logic [AW-1:0] ad, logic [DW-1:0] wd);
    cmd_t c;
    c.we = w; c.addr = ad; c.wd = wd;
    return c;
  endfunction

  vec_t vt[8];
  int launch;

  initial begin
    vt[0] = '{1, 1, 4, 32'h11, 1, 1, 5, 32'h22, 1, 3, 0, 0};
    vt[1] = '{1, 1, 10, 32'hFF, 0, 0, 0, 0, 1, -1, 0, 0};
    vt[2] = '{1, 0, 10, 0, 0, 0, 0, 0, 1, -1, 32'hFF, 0};
    vt[3] = '{0, 0, 0, 0, 1, 0, 5, 0, -1, 1, 32'hFF, 32'h22};
    vt[4] = '{1, 0, 4, 0, 1, 0, 10, 0, 1, 4, 32'h11, 32'hFF};
    vt[5] = '{1, 1, 10, 32'h33, 1, 0, 10, 0, 1, 3, 32'h11, 32'h33};
    vt[6] = '{0, 0, 0, 0, 1, 1, 4, 32'h44, -1, 1, 32'h11, 32'h33};
    vt[7] = '{1, 0, 4, 0, 1, 1, 6, 32'h77, 1, 4, 32'h44, 32'h33};
    drive();
    predict();
    tick();
    rst_drv = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 8; i++) begin
      if (vt[i].a_v) aq.push_back(mk(vt[i].a_w, vt[i].a_ad, vt[i].a_wd));
      if (vt[i].b_v) bq.push_back(mk(vt[i].b_w, vt[i].b_ad, vt[i].b_wd));
      a_gcyc = -1;
      b_gcyc = -1;
      launch = cyc + 1;
      run_until_idle(30);
      chk($sformatf("vec%0d_a_gnt_offset", i), a_gcyc < 0 ? -1 : a_gcyc - launch, vt[i].a_off);
      chk($sformatf("vec%0d_b_gnt_offset", i), b_gcyc < 0 ? -1 : b_gcyc - launch, vt[i].b_off);
      chk($sformatf("vec%0d_a_rdata", i), a_rdata, vt[i].a_rd);
      chk($sformatf("vec%0d_b_rdata", i), b_rdata, vt[i].b_rd);
    end
    // both requesters hold reads continuously: grants must alternate starting with A
    do_reset();
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      aq.push_back(mk(1'b0, AW'(i), '0));
      bq.push_back(mk(1'b0, AW'(i + 4), '0));
    end
    run_until_idle(60);
    chk("fair_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) chk($sformatf("fair_order%0d", i), 32'(glog[i]), 32'(i % 2));
    // reset in the ISSUE cycle of a B read discards its result
    b_rv_cnt = 0;
    bq.push_back(mk(1'b0, 5, '0));
    launch = cyc + 1;
    tick();
    rst_drv = 1'b1;
    tick();
    rst_drv = 1'b0;
    chk("abort_b_gnt_cycle", b_gcyc, launch + 1);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_b_rvalid", b_rv_cnt, 0);
    chk("abort_busy", 32'(busy), 32'd0);
    aq.push_back(mk(1'b0, 4, '0));
    bq.push_back(mk(1'b0, 5, '0));
    a_gcyc = -1;
    b_gcyc = -1;
    launch = cyc + 1;
    run_until_idle(30);
    chk("after_abort_a_first", a_gcyc - launch, 1);
    chk("after_abort_b_second", b_gcyc - launch, 4);
    // A write arriving while a B read is in flight waits for the read to finish
    bq.push_back(mk(1'b0, 5, '0));
    tick();
    aq.push_back(mk(1'b1, 7, 32'h55));
    run_until_idle(30);
    chk("pending_a_after_b", a_gcyc - b_gcyc, 3);
    chk("pending_b_rdata", b_rdata, 32'h22);
    for (int i = 0; i < 2000; i++) begin
      if (aq.size() < 2 && $urandom_range(2) == 0) aq.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom));
      if (bq.size() < 2 && $urandom_range(2) == 0) bq.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom));
      rst_drv = $urandom_range(99) == 0;
      tick();
    end
    rst_drv = 1'b0;
    run_until_idle(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port-pair `ram` block.
- Accepts read/write commands from requesters A and B and serialises them onto the RAM `rd_en`/`wr_en` interface.
- Returns read data with a per-requester valid pulse.
- Sits between client logic (e.g. DMA, CPU-side port) and the `ram` instance. RAM read data is registered, so it is valid the cycle after `rd_en` is sampled.

Parameters:
- DW, 32, data width (matches RAM `wr_data`/`rd_data`).
- AW, 32, address width (matches RAM `wr_addr`/`rd_addr`).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A command valid; held with command stable until a_gnt seen.
- a_we  in  1  A command type: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  one-cycle pulse: A command issued to RAM.
- a_rvalid  out  1  one-cycle pulse: a_rdata valid.
- a_rdata  out  DW  A read data, held until next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: as A, for requester B.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  AW  to RAM wr_addr.
- ram_wr_data  out  DW  to RAM wr_data.
- ram_rd_en  out  1  to RAM rd_en.
- ram_rd_addr  out  AW  to RAM rd_addr.
- ram_rd_data  in  DW  from RAM rd_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst = 1 at a rising edge):
  - state <= IDLE.
  - All en/gnt/rvalid/busy <= 0; all addr/data/rdata outputs <= 0.
  - Round-robin pointer <= "last = B", so A wins the first tie.
  - Reset mid-operation aborts any issued or pending command: no gnt and no rvalid pulse after reset, and a pending read result is discarded.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE, at a clock edge with any req high:
  - Winner = the sole requester, or on a tie the one not granted last.
  - Latch owner and we; update round-robin pointer to the owner.
  - Drive the owner's gnt = 1.
  - If we = 1: ram_wr_en = 1, ram_wr_addr/ram_wr_data = owner's addr/wdata.
  - If we = 0: ram_rd_en = 1, ram_rd_addr = owner's addr.
  - Go to ISSUE.
  - With no req: stay in IDLE, outputs idle.
- ISSUE (exactly 1 cycle; the RAM samples the enable at the end of this cycle):
  - Deassert gnt, ram_wr_en and ram_rd_en.
  - Write goes to IDLE; read goes to RDWAIT.
- RDWAIT (1 cycle):
  - Capture ram_rd_data into owner's rdata; pulse owner's rvalid.
  - Go to IDLE.
- Latency:
  - gnt is high in the cycle following the edge that sampled req.
  - rvalid is high 2 cycles after gnt.
  - Write occupancy: 2 cycles. Read occupancy: 3 cycles.
  - Max throughput: one command per 2 cycles (writes), per 3 cycles (reads).
- Requester rule: drop or change req on the edge after gnt is seen high. The arbiter does not resample req until it is back in IDLE, so double-grant is impossible.
- Non-selected address/data outputs hold their previous values. ram_wr_en and ram_rd_en are never high together.
- Starvation: with both req held continuously, grants strictly alternate A, B, A, B, ...
- A requester raising req while busy waits; no command loss. The other requester's rdata is never modified.
- Command fields are sampled only in IDLE at the grant edge; changes to a_*/b_* outside that edge are ignored.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, then 0, no req -> all outputs 0, busy = 0 for 10 cycles.
- Single write then read by A:
  - a_we = 1, addr = 10, wdata = 32'hFF -> a_gnt pulse with ram_wr_en = 1, ram_wr_addr = 10, ram_wr_data = 32'hFF for exactly 1 cycle.
  - Then read of addr = 10 -> ram_rd_en = 1 for 1 cycle, a_rvalid 2 cycles after a_gnt, a_rdata = 32'hFF; b_rvalid stays 0.
- Simultaneous requests after reset: A writes addr 4 = 32'h11, B writes addr 5 = 32'h22 in the same cycle -> A granted first, B granted exactly 2 cycles later; the RAM holds both values on readback.
- Fairness: A and B both hold reads for 6 consecutive grants -> gnt order A, B, A, B, A, B; each rvalid is routed to the correct owner with the correct data.
- Reset mid-read: assert rst in the ISSUE cycle of a B read -> no b_rvalid ever, state IDLE, busy = 0. The next A request is granted first.
- Read from B while A write pending: B read is issued first, then A gets a_gnt in the cycle after B's RDWAIT. Check ram_wr_en and ram_rd_en are never both high.
